// File: rtl/mips_cpu_bus_arbiter.sv
// mips_cpu_bus_arbiter: N-master round-robin arbiter for the Avalon-MM bus.
// Optional build macro MIPS_BUS_ARB_LOCK_EN adds m_lock for locked bursts.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   m_address         packed master addresses, master i at [i*ADDR_W +: ADDR_W]
//   m_read/m_write    per-master strobes; request = read | write
//   m_writedata       packed master write data
//   m_byteenable      packed master byte enables
//   m_waitrequest     per-master waitrequest (1 unless owner)
//   m_readdata        slave read data broadcast to every master
//   s_*               single slave port, driven from the granted master
//   m_lock            (MIPS_BUS_ARB_LOCK_EN only) hold grant across completion
//   grant             one-hot current owner, 0 while idle

module mips_cpu_bus_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BE_W      = DATA_W / 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_MASTERS*ADDR_W-1:0] m_address,
  input  logic [N_MASTERS-1:0]        m_read,
  input  logic [N_MASTERS-1:0]        m_write,
  input  logic [N_MASTERS*DATA_W-1:0] m_writedata,
  input  logic [N_MASTERS*BE_W-1:0]   m_byteenable,
  output logic [N_MASTERS-1:0]        m_waitrequest,
  output logic [DATA_W-1:0]           m_readdata,
  output logic [ADDR_W-1:0]           s_address,
  output logic                        s_read,
  output logic                        s_write,
  output logic [DATA_W-1:0]           s_writedata,
  output logic [BE_W-1:0]             s_byteenable,
  input  logic                        s_waitrequest,
  input  logic [DATA_W-1:0]           s_readdata,
`ifdef MIPS_BUS_ARB_LOCK_EN
  input  logic [N_MASTERS-1:0]        m_lock,
`endif
  output logic [N_MASTERS-1:0]        grant
);

  localparam int LW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [LW-1:0]        last_q,  last_d;

  logic [N_MASTERS-1:0] req;
  int                   gi;
  int                   win;
  logic                 found;
  logic                 own_wr;
  logic                 own_rd;
  logic                 strobe;
  logic                 done;
  logic                 lock_g;

  assign req        = m_read | m_write;
  assign m_readdata = s_readdata;
  assign grant      = grant_q;

  // Owner index recovered from the one-hot grant.
  always_comb begin
    gi = 0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant_q[i]) gi = i;
    end
  end

  // Round-robin pick: first requester after the last completed owner.
  always_comb begin
    win   = 0;
    found = 1'b0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      int idx;
      idx = (int'(last_q) + k) % N_MASTERS;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Owner strobes; write wins when both are raised.
  always_comb begin
    own_wr = 1'b0;
    own_rd = 1'b0;
    if (!reset && state_q == BUSY) begin
      own_wr = m_write[gi];
      own_rd = m_read[gi] & ~m_write[gi];
    end
  end

  assign strobe = own_wr | own_rd;
  assign done   = strobe & ~s_waitrequest;

`ifdef MIPS_BUS_ARB_LOCK_EN
  assign lock_g = m_lock[gi];
`else
  assign lock_g = 1'b0;
`endif

  // Slave-side mux; payload is zeroed whenever no strobe is driven.
  always_comb begin
    s_read        = own_rd;
    s_write       = own_wr;
    s_address     = '0;
    s_writedata   = '0;
    s_byteenable  = '0;
    m_waitrequest = '1;
    if (strobe) begin
      s_address    = m_address[gi*ADDR_W +: ADDR_W];
      s_writedata  = m_writedata[gi*DATA_W +: DATA_W];
      s_byteenable = m_byteenable[gi*BE_W +: BE_W];
    end
    if (!reset && state_q == BUSY) begin
      m_waitrequest[gi] = s_waitrequest;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          for (int i = 0; i < N_MASTERS; i++) begin
            grant_d[i] = (i == win);
          end
        end
      end
      BUSY: begin
        if (!strobe) begin
          // Owner withdrew: abandon without moving the rotation.
          state_d = IDLE;
          grant_d = '0;
        end else if (done && !lock_g) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = LW'(gi);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LW'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule
